// File: rtl/rr_req_arbiter.sv
// Round-robin request/grant arbiter with a MAX_HOLD tenure limit and a preemption pulse.
// Optional build macro ARB_ASSERT_EN compiles in concurrent protocol assertions.
module rr_req_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 preempt
);

    localparam int ID_W   = $clog2(N);
    localparam int HOLD_W = $clog2(MAX_HOLD);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(N - 1);
    localparam logic [N-1:0]      GNT_ONE   = N'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [N-1:0]       gnt_r;
    logic [N-1:0]       gnt_s;
    logic [ID_W-1:0]    gnt_id_r;
    logic [ID_W-1:0]    gnt_id_s;
    logic               busy_r;
    logic               busy_s;
    logic               preempt_r;
    logic               preempt_s;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic [HOLD_W-1:0]  hold_cnt_s;
    logic [ID_W-1:0]    last_owner_r;
    logic [ID_W-1:0]    last_owner_s;

    logic [N-1:0]       others_s;
    logic               owner_req_s;
    logic [ID_W:0]      pick_s;
    logic               do_grant_s;

    // Round-robin search: first set bit of vec starting at last+1, wrapping; MSB of result = found.
    // Scanning from the farthest candidate down lets the nearest one overwrite the result.
    function automatic logic [ID_W:0] rr_pick(input logic [N-1:0]    vec,
                                              input logic [ID_W-1:0] last);
        logic [ID_W:0] result;
        int            idx;
        result = {(ID_W + 1){1'b0}};
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (vec[idx]) begin
                result = {1'b1, ID_W'(idx)};
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Next-state, grant selection and hold-counter logic
    always_comb begin
        state_s      = state_r;
        gnt_s        = gnt_r;
        gnt_id_s     = gnt_id_r;
        hold_cnt_s   = hold_cnt_r;
        last_owner_s = last_owner_r;
        preempt_s    = 1'b0;
        do_grant_s   = 1'b0;

        // The owner is masked out so a preemption never re-selects it.
        others_s    = req & ~gnt_r;
        owner_req_s = |(req & gnt_r);
        pick_s      = rr_pick(others_s, last_owner_r);

        case (state_r)
            IDLE: begin
                if (pick_s[ID_W]) begin
                    do_grant_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            OWNED: begin
                if (!owner_req_s) begin
                    if (pick_s[ID_W]) begin
                        do_grant_s = 1'b1;
                    end else begin
                        state_s    = IDLE;
                        gnt_s      = {N{1'b0}};
                        gnt_id_s   = {ID_W{1'b0}};
                        hold_cnt_s = {HOLD_W{1'b0}};
                    end
                end else if (hold_cnt_r == HOLD_LAST) begin
                    if (pick_s[ID_W]) begin
                        do_grant_s = 1'b1;
                        preempt_s  = 1'b1;
                    end else begin
                        // Nobody waiting: the owner simply starts a fresh tenure.
                        hold_cnt_s = {HOLD_W{1'b0}};
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_ONE;
                end
            end
            default: begin
                state_s    = IDLE;
                gnt_s      = {N{1'b0}};
                gnt_id_s   = {ID_W{1'b0}};
                hold_cnt_s = {HOLD_W{1'b0}};
            end
        endcase

        if (do_grant_s) begin
            state_s      = OWNED;
            gnt_s        = GNT_ONE << pick_s[ID_W-1:0];
            gnt_id_s     = pick_s[ID_W-1:0];
            hold_cnt_s   = {HOLD_W{1'b0}};
            last_owner_s = pick_s[ID_W-1:0];
        end else begin
            last_owner_s = last_owner_s;
        end

        busy_s = (state_s == OWNED);
    end

    // State and registered output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            gnt_r        <= {N{1'b0}};
            gnt_id_r     <= {ID_W{1'b0}};
            busy_r       <= 1'b0;
            preempt_r    <= 1'b0;
            hold_cnt_r   <= {HOLD_W{1'b0}};
            last_owner_r <= ID_LAST;
        end else begin
            state_r      <= state_s;
            gnt_r        <= gnt_s;
            gnt_id_r     <= gnt_id_s;
            busy_r       <= busy_s;
            preempt_r    <= preempt_s;
            hold_cnt_r   <= hold_cnt_s;
            last_owner_r <= last_owner_s;
        end
    end

    assign gnt     = gnt_r;
    assign gnt_id  = gnt_id_r;
    assign busy    = busy_r;
    assign preempt = preempt_r;

`ifdef ARB_ASSERT_EN
    localparam int WAIT_LIMIT = N * MAX_HOLD;
    localparam int WAIT_W     = $clog2(WAIT_LIMIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    logic [WAIT_W-1:0] wait_cnt_r [N];

    // Consecutive cycles each requester has been pending without its grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                wait_cnt_r[i] <= {WAIT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && !gnt[i]) begin
                    if (wait_cnt_r[i] != WAIT_SAT) begin
                        wait_cnt_r[i] <= wait_cnt_r[i] + WAIT_ONE;
                    end else begin
                        wait_cnt_r[i] <= wait_cnt_r[i];
                    end
                end else begin
                    wait_cnt_r[i] <= {WAIT_W{1'b0}};
                end
            end
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
        else $error("gnt not onehot0 at t=%0t", $time);

    a_preempt: assert property (@(posedge clk) disable iff (!rst_n) preempt |-> $past(busy))
        else $error("preempt without prior busy at t=%0t", $time);

    for (genvar g = 0; g < N; g++) begin : g_req_chk
        a_gnt_req: assert property (@(posedge clk) disable iff (!rst_n) gnt[g] |-> $past(req[g]))
            else $error("grant without request at t=%0t", $time);
        // Pending request must be granted within N*MAX_HOLD cycles.
        a_live: assert property (@(posedge clk) disable iff (!rst_n) wait_cnt_r[g] <= WAIT_MAX)
            else $error("request starved at t=%0t", $time);
    end
`endif

endmodule
